// File: rtl/dcc_cmd_scheduler_if.sv
// Packet handshake between the DCC command scheduler (master) and the bit encoder (slave).
interface dcc_cmd_scheduler_if;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [31:0] pkt_data;  // {addr, instr, data, err}
  logic        pkt_long;  // 1: data byte is sent, 0: data byte ignored

  modport master (
    output pkt_valid,
    output pkt_data,
    output pkt_long,
    input  pkt_ready
  );

  modport slave (
    input  pkt_valid,
    input  pkt_data,
    input  pkt_long,
    output pkt_ready
  );
endinterface

// File: rtl/dcc_cmd_scheduler.sv
// dcc_cmd_scheduler: round-robin walk of the DCC command memory. Each enabled slot becomes a
// packet with a computed error byte, repeated R+1 times. Idle packets fill empty sweeps.
// Optional feature macro: DCC_SCHED_ESTOP_EN (honour estop_i with broadcast stop packets).
module dcc_cmd_scheduler #(
  parameter int unsigned IDX_W = 10
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic                       enable_i,
  input  logic [IDX_W-1:0]           num_slots_i,
  input  logic                       estop_i,
  output logic [IDX_W-1:0]           cmd_index_o,
  input  logic [31:0]                cmd_word_i,
  dcc_cmd_scheduler_if.master        pkt_if,
  output logic                       busy_o
);

  localparam logic [31:0] IdlePkt = 32'hFF00_00FF;
  localparam logic [31:0] StopPkt = 32'h0041_0041;

  typedef enum logic [1:0] {StIdle, StFetch, StWait, StSend} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cur_q, cur_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [2:0]       rep_q, rep_d;
  logic [31:0]      data_q, data_d;
  logic             long_q, long_d;
  // Current payload is a substitute (idle/stop): the slot pointer is not advanced after it.
  logic             sub_q, sub_d;

  logic estop_act;
`ifdef DCC_SCHED_ESTOP_EN
  assign estop_act = estop_i;
  logic [2:0] unused_rsvd;
  assign unused_rsvd = cmd_word_i[26:24];
`else
  assign estop_act = 1'b0;
  logic [3:0] unused_in;
  assign unused_in = {estop_i, cmd_word_i[26:24]};
`endif

  // Field decode of the memory word and packet assembly.
  logic [7:0]  w_addr, w_instr, w_data;
  logic        w_long;
  logic [2:0]  w_rep;
  logic [31:0] w_pkt;
  assign w_long  = cmd_word_i[30];
  assign w_rep   = cmd_word_i[29:27];
  assign w_addr  = cmd_word_i[23:16];
  assign w_instr = cmd_word_i[15:8];
  assign w_data  = cmd_word_i[7:0];
  assign w_pkt   = {w_addr, w_instr, w_data, w_addr ^ w_instr ^ (w_long ? w_data : 8'h00)};

  // Widened arithmetic so num_slots_i == 0 wraps the pointer to 0 instead of overflowing.
  logic [IDX_W:0]   num_ext, cur_inc, sweep_inc;
  logic [IDX_W-1:0] next_slot;
  logic             num_zero;
  assign num_ext   = {1'b0, num_slots_i};
  assign cur_inc   = {1'b0, cur_q} + (IDX_W+1)'(1);
  assign sweep_inc = {1'b0, sweep_q} + (IDX_W+1)'(1);
  assign next_slot = (cur_inc >= num_ext) ? '0 : cur_inc[IDX_W-1:0];
  assign num_zero  = (num_slots_i == '0);

  assign cmd_index_o = cur_q;

  // State register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: slot pointer, repeat and sweep counters, held payload.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cur_q   <= '0;
      sweep_q <= '0;
      rep_q   <= '0;
      data_q  <= '0;
      long_q  <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      sweep_q <= sweep_d;
      rep_q   <= rep_d;
      data_q  <= data_d;
      long_q  <= long_d;
      sub_q   <= sub_d;
    end
  end

  // Next-state and next-datapath decisions.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    sweep_d = sweep_q;
    rep_d   = rep_q;
    data_d  = data_q;
    long_d  = long_q;
    sub_d   = sub_q;
    unique case (state_q)
      StIdle: begin
        if (estop_act) begin
          {data_d, long_d, sub_d, rep_d} = {StopPkt, 1'b0, 1'b1, 3'd0};
          state_d = StSend;
        end else if (enable_i && num_zero) begin
          {data_d, long_d, sub_d, rep_d} = {IdlePkt, 1'b0, 1'b1, 3'd0};
          state_d = StSend;
        end else if (enable_i) begin
          state_d = StFetch;
        end
      end
      StFetch, StWait: begin
        if (estop_act) begin
          {data_d, long_d, sub_d, rep_d} = {StopPkt, 1'b0, 1'b1, 3'd0};
          state_d = StSend;
        end else if (!enable_i) begin
          {cur_d, sweep_d, rep_d} = '0;
          state_d = StIdle;
        end else if (state_q == StFetch) begin
          state_d = StWait;
        end else if (cmd_word_i[31]) begin
          {data_d, long_d, sub_d, rep_d} = {w_pkt, w_long, 1'b0, w_rep};
          sweep_d = '0;
          state_d = StSend;
        end else begin
          cur_d = next_slot;
          if (sweep_inc >= num_ext) begin
            // A whole sweep found nothing to send: fill the track with one idle packet.
            {data_d, long_d, sub_d, rep_d} = {IdlePkt, 1'b0, 1'b1, 3'd0};
            sweep_d = '0;
            state_d = StSend;
          end else begin
            sweep_d = sweep_inc[IDX_W-1:0];
            state_d = StFetch;
          end
        end
      end
      StSend: begin
        // Payload is frozen until the encoder takes it.
        if (pkt_if.pkt_ready) begin
          if (estop_act) begin
            {data_d, long_d, sub_d, rep_d} = {StopPkt, 1'b0, 1'b1, 3'd0};
          end else if (!enable_i) begin
            {cur_d, sweep_d, rep_d} = '0;
            state_d = StIdle;
          end else if (sub_q) begin
            if (num_zero) begin
              {data_d, long_d, sub_d, rep_d} = {IdlePkt, 1'b0, 1'b1, 3'd0};
            end else begin
              state_d = StFetch;
            end
          end else if (rep_q != 3'd0) begin
            rep_d = rep_q - 3'd1;
          end else begin
            cur_d   = next_slot;
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state and held payload.
  always_comb begin
    pkt_if.pkt_valid = (state_q == StSend);
    pkt_if.pkt_data  = data_q;
    pkt_if.pkt_long  = long_q;
    busy_o           = (state_q != StIdle);
  end

endmodule
